// File: rtl/mult_stream_pkg.sv
// Shared types and helpers for the multiplier result stream stages.
// Stream results are packed {ovf, data}: overflow flag in the MSB, sum below it.
package mult_stream_pkg;

   localparam int unsigned WL_DEFAULT = 32;

   function automatic int unsigned len_w(input int unsigned max_len);
      return $clog2(max_len + 1);
   endfunction

   typedef enum logic {
      StIdle,
      StAccum
   } acc_state_e;

   typedef enum logic {
      StEmpty,
      StFull
   } out_state_e;

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready output register; load_ok_o says whether a load this
// cycle is taken (empty, or full and draining in the same cycle).
module stream_out_reg
   import mult_stream_pkg::*;
#(
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             load_i,
   input  logic [Width-1:0] data_i,
   output logic             load_ok_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [Width-1:0] data_o
);

   out_state_e       state_q, state_d;
   logic [Width-1:0] data_q, data_d;

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      load_ok_o = (state_q == StEmpty) || ready_i;
      if (load_i && load_ok_o) begin
         state_d = StFull;
         data_d  = data_i;
      end else if ((state_q == StFull) && ready_i) begin
         state_d = StEmpty;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StEmpty;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = (state_q == StFull);
   assign data_o  = data_q;

endmodule

// File: rtl/product_accumulator.sv
// Sums a programmable number of consecutive multiplier products per frame and
// presents each frame sum on a valid/ready port; results that cannot load are dropped.
module product_accumulator
   import mult_stream_pkg::*;
#(
   parameter int unsigned WL      = WL_DEFAULT,
   parameter int unsigned ACC_WL  = 2 * WL + 8,
   parameter int unsigned MAX_LEN = 256,
   localparam int unsigned LEN_W  = len_w(MAX_LEN)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [2*WL-1:0]   in_product,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic              clear,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_WL-1:0] out_data,
   output logic              out_ovf,
   output logic              busy,
   output logic              err_drop
);

   typedef struct packed {
      logic              ovf;
      logic [ACC_WL-1:0] data;
   } result_t;

   localparam int unsigned SumW = ACC_WL + 1;
   localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_LEN);

   acc_state_e        state_q, state_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [ACC_WL-1:0] acc_q, acc_d;
   logic              ovf_q, ovf_d;
   logic              err_drop_q, err_drop_d;

   logic              beat, first, complete, load_ok;
   logic [LEN_W-1:0]  cfg_eff, cur_len;
   logic [SumW-1:0]   sum_ext;
   logic              ovf_next;
   result_t           res_in, res_out;

   always_comb begin
      cfg_eff  = ((cfg_len == '0) || (cfg_len > MaxLen)) ? MaxLen : cfg_len;
      beat     = in_valid && !clear;
      first    = (state_q == StIdle);
      cur_len  = first ? cfg_eff : len_q;
      // One extra bit captures the carry out of the accumulator width.
      sum_ext  = first ? SumW'(in_product) : SumW'(acc_q) + SumW'(in_product);
      ovf_next = !first && (ovf_q || sum_ext[ACC_WL]);
      complete = beat && ((cnt_q + LEN_W'(1)) == cur_len);
      res_in   = '{ovf: ovf_next, data: sum_ext[ACC_WL-1:0]};
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      acc_d      = acc_q;
      ovf_d      = ovf_q;
      err_drop_d = complete && !load_ok;
      if (clear) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else if (beat) begin
         acc_d = sum_ext[ACC_WL-1:0];
         ovf_d = ovf_next;
         len_d = cur_len;
         if (complete) begin
            state_d = StIdle;
            cnt_d   = '0;
         end else begin
            state_d = StAccum;
            cnt_d   = cnt_q + LEN_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         len_q      <= '0;
         acc_q      <= '0;
         ovf_q      <= 1'b0;
         err_drop_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         acc_q      <= acc_d;
         ovf_q      <= ovf_d;
         err_drop_q <= err_drop_d;
      end
   end

   stream_out_reg #(
      .Width(ACC_WL + 1)
   ) u_out_reg (
      .clk_i    (clk),
      .reset_i  (reset),
      .load_i   (complete),
      .data_i   (res_in),
      .load_ok_o(load_ok),
      .valid_o  (out_valid),
      .ready_i  (out_ready),
      .data_o   (res_out)
   );

   assign out_data = res_out.data;
   assign out_ovf  = res_out.ovf;
   assign busy     = (cnt_q != '0);
   assign err_drop = err_drop_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized scoreboard bench: a frame-level reference model queues expected results,
// a monitor compares every presented output against the queue head.
module tb_product_accumulator;

   localparam int unsigned WL      = 8;
   localparam int unsigned ACC_WL  = 16;
   localparam int unsigned MAX_LEN = 8;
   localparam int unsigned LEN_W   = 4;

   typedef struct packed {
      logic              ovf;
      logic [ACC_WL-1:0] data;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid = 1'b0;
   logic [2*WL-1:0]   in_product = '0;
   logic [LEN_W-1:0]  cfg_len = '0;
   logic              clear = 1'b0;
   logic              out_ready = 1'b0;
   logic              out_valid;
   logic [ACC_WL-1:0] out_data;
   logic              out_ovf;
   logic              busy;
   logic              err_drop;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   exp_t   exp_q[$];
   int     m_cnt = 0;
   int     m_len = 0;
   longint m_sum = 0;
   bit     m_full = 0;
   bit     exp_drop = 0;
   bit     rst_seen = 0;
   bit     checking = 0;

   product_accumulator #(
      .WL     (WL),
      .ACC_WL (ACC_WL),
      .MAX_LEN(MAX_LEN)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_product(in_product),
      .cfg_len   (cfg_len),
      .clear     (clear),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf),
      .busy      (busy),
      .err_drop  (err_drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Frame-level model: sums whole frames with plain arithmetic.
   always @(posedge clk) begin
      bit done, accepted;
      exp_t e;
      done     = 0;
      accepted = m_full && out_ready;
      checking = 1;
      if (reset) begin
         m_cnt = 0;
         m_sum = 0;
         m_full = 0;
         exp_drop = 0;
         rst_seen = 1;
         exp_q.delete();
      end else begin
         rst_seen = 0;
         exp_drop = 0;
         if (clear) begin
            m_cnt = 0;
         end else if (in_valid) begin
            if (m_cnt == 0) begin
               m_len = (cfg_len == 0 || int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
               m_sum = 0;
            end
            m_sum += longint'(in_product);
            m_cnt++;
            if (m_cnt == m_len) begin
               m_cnt = 0;
               done  = 1;
            end
         end
         if (done) begin
            if (!m_full || accepted) begin
               e.data = m_sum[ACC_WL-1:0];
               e.ovf  = (m_sum >= (longint'(1) << ACC_WL));
               exp_q.push_back(e);
               m_full = 1;
            end else begin
               exp_drop = 1;
            end
         end else if (accepted) begin
            m_full = 0;
         end
      end
   end

   // Monitor: compares DUT outputs against the scoreboard on the falling edge.
   always @(negedge clk) begin
      if (checking) begin
         chk("out_valid", 32'(out_valid), 32'(m_full));
         chk("err_drop", 32'(err_drop), 32'(exp_drop));
         chk("busy", 32'(busy), 32'(m_cnt != 0));
         if (rst_seen) begin
            chk("reset out_data", 32'(out_data), 32'd0);
            chk("reset out_ovf", 32'(out_ovf), 32'd0);
         end
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected result", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
               chk("out_data", 32'(out_data), 32'(exp_q[0].data));
               chk("out_ovf", 32'(out_ovf), 32'(exp_q[0].ovf));
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic drive(input logic v, input logic [2*WL-1:0] p, input logic [LEN_W-1:0] l,
                        input logic c, input logic r, input logic rs);
      @(posedge clk);
      #1;
      in_valid   = v;
      in_product = p;
      cfg_len    = l;
      clear      = c;
      out_ready  = r;
      reset      = rs;
   endtask

   task automatic idle(input logic r, input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, 4'd1, 1'b0, r, 1'b0);
   endtask

   initial begin
      drive(1'b0, '0, 4'd0, 1'b0, 1'b0, 1'b1);
      idle(1'b1, 2);
      // Basic sum, len 4
      drive(1'b1, 16'd10, 4'd4, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 16'd20, 4'd4, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 16'd30, 4'd4, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 16'd40, 4'd4, 1'b0, 1'b1, 1'b0);
      idle(1'b1, 2);
      // One-beat frames
      drive(1'b1, 16'd5, 4'd1, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 16'd6, 4'd1, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 16'd7, 4'd1, 1'b0, 1'b1, 1'b0);
      idle(1'b1, 2);
      // Backpressure and drop
      drive(1'b1, 16'd1, 4'd2, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 16'd2, 4'd2, 1'b0, 1'b0, 1'b0);
      idle(1'b0, 2);
      drive(1'b1, 16'd4, 4'd2, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 16'd4, 4'd2, 1'b0, 1'b0, 1'b0);
      idle(1'b0, 2);
      idle(1'b1, 2);
      // Drain-and-refill
      drive(1'b1, 16'd3, 4'd2, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 16'd3, 4'd2, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 16'd5, 4'd2, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 16'd6, 4'd2, 1'b0, 1'b1, 1'b0);
      idle(1'b1, 2);
      // Overflow then a clean frame
      drive(1'b1, 16'd65025, 4'd2, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 16'd65025, 4'd2, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 16'd1, 4'd2, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 16'd1, 4'd2, 1'b0, 1'b1, 1'b0);
      idle(1'b1, 2);
      // Clear with a coincident beat
      drive(1'b1, 16'd7, 4'd4, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 16'd8, 4'd4, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 16'd9, 4'd4, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b1, 16'd1, 4'd4, 1'b0, 1'b1, 1'b0);
      idle(1'b1, 2);
      // Length 0 and out-of-range length both mean MAX_LEN
      for (int i = 0; i < 8; i++) drive(1'b1, 16'd2, 4'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) drive(1'b1, 16'd3, 4'd12, 1'b0, 1'b1, 1'b0);
      idle(1'b1, 2);
      // Reset mid-frame with a result pending
      drive(1'b1, 16'd3, 4'd1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 16'd1, 4'd3, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 16'd2, 4'd3, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 16'd2, 4'd3, 1'b0, 1'b0, 1'b1);
      idle(1'b1, 2);
      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 9) < 7,
               ($urandom_range(0, 3) == 0) ? 16'd65025 : 16'($urandom),
               4'($urandom_range(0, 15)),
               $urandom_range(0, 29) == 0,
               $urandom_range(0, 9) < 6,
               $urandom_range(0, 199) == 0);
      end
      idle(1'b1, 4);
      @(posedge clk);
      checking = 0;
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
